// File: rtl/mac_window.sv
// mac_window: four-lane signed 8x8 dot product plus bias, computed one lane
// per cycle into a 20-bit accumulator. The sum is arithmetically shifted,
// saturated to a signed byte and optionally clamped at zero (ReLU).
module mac_window #(
    parameter int SHIFT = 7,
    parameter int RELU  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic signed [7:0] din0,
    input  logic signed [7:0] din1,
    input  logic signed [7:0] din2,
    input  logic signed [7:0] din3,
    input  logic signed [7:0] wt0,
    input  logic signed [7:0] wt1,
    input  logic signed [7:0] wt2,
    input  logic signed [7:0] wt3,
    input  logic signed [15:0] bias,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [3:0][7:0]    din_r;
    logic [3:0][7:0]    wt_r;
    logic signed [19:0] acc_r;
    logic [1:0]         idx_r;
    logic               busy_r;
    logic               done_r;
    logic [7:0]         result_r;

    logic signed [15:0] prod_s;
    logic signed [19:0] shifted_s;

    // Saturate the full-width shifted sum to a signed byte, then apply ReLU.
    function automatic logic [7:0] sat_relu(input logic signed [19:0] v);
        logic [7:0] s;
        if (v > 20'sd127) begin
            s = 8'h7F;
        end else if (v < -20'sd128) begin
            s = 8'h80;
        end else begin
            s = v[7:0];
        end
        return ((RELU != 0) && s[7]) ? 8'h00 : s;
    endfunction

    // Product of the currently selected lane; 16 bits hold even -128*-128.
    always_comb begin
        prod_s    = 16'($signed(din_r[idx_r])) * 16'($signed(wt_r[idx_r]));
        shifted_s = acc_r >>> SHIFT;
    end

    // Control FSM with datapath registers; outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            din_r    <= '0;
            wt_r     <= '0;
            acc_r    <= 20'sd0;
            idx_r    <= 2'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        din_r   <= {din3, din2, din1, din0};
                        wt_r    <= {wt3, wt2, wt1, wt0};
                        acc_r   <= 20'(bias);
                        idx_r   <= 2'd0;
                        busy_r  <= 1'b1;
                        state_r <= MAC;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                MAC: begin
                    acc_r <= acc_r + 20'(prod_s);
                    idx_r <= idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        state_r <= OUT;
                    end else begin
                        state_r <= MAC;
                    end
                end
                OUT: begin
                    result_r <= sat_relu(shifted_s);
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= DONE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_mac_window.sv
// Testbench for mac_window: table-driven vectors, randomized operations checked
// against an arithmetic reference model, and handshake/reset sequences.
// Two instances run in parallel: RELU=1 (dut) and RELU=0 (dut0).
module tb_mac_window;

    localparam int SHIFT = 7;

    logic              clk;
    logic              rst;
    logic              start;
    logic signed [7:0] din0, din1, din2, din3;
    logic signed [7:0] wt0, wt1, wt2, wt3;
    logic signed [15:0] bias;
    logic              busy, done, busy0, done0;
    logic [7:0]        result, result0;

    int n_checks;
    int n_fail;

    mac_window #(.SHIFT(SHIFT), .RELU(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .wt0(wt0), .wt1(wt1), .wt2(wt2), .wt3(wt3),
        .bias(bias), .busy(busy), .done(done), .result(result)
    );

    mac_window #(.SHIFT(SHIFT), .RELU(0)) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .wt0(wt0), .wt1(wt1), .wt2(wt2), .wt3(wt3),
        .bias(bias), .busy(busy0), .done(done0), .result(result0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dw;   // {din3,din2,din1,din0}
        logic [31:0] ww;   // {wt3,wt2,wt1,wt0}
        logic [15:0] b;
        logic [7:0]  e1;   // expected with ReLU
        logic [7:0]  e0;   // expected without ReLU
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, floor division by 2^SHIFT, clamp, ReLU.
    function automatic logic [7:0] ref_out(input logic [31:0] dw, input logic [31:0] ww,
                                           input logic [15:0] b, input bit relu);
        int acc;
        int q;
        int div;
        logic [7:0] db;
        logic [7:0] wb;
        div = 1 << SHIFT;
        acc = int'($signed(b));
        for (int i = 0; i < 4; i++) begin
            db = dw[8*i +: 8];
            wb = ww[8*i +: 8];
            acc = acc + int'($signed(db)) * int'($signed(wb));
        end
        if (acc >= 0) q = acc / div;
        else          q = -((-acc + div - 1) / div);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        if (relu && q < 0) q = 0;
        return q[7:0];
    endfunction

    task automatic apply(input logic [31:0] dw, input logic [31:0] ww, input logic [15:0] b);
        din0 = dw[7:0];   din1 = dw[15:8];  din2 = dw[23:16]; din3 = dw[31:24];
        wt0  = ww[7:0];   wt1  = ww[15:8];  wt2  = ww[23:16]; wt3  = ww[31:24];
        bias = b;
    endtask

    task automatic scramble();
        apply($urandom, $urandom, 16'($urandom));
    endtask

    // One full operation: accept in cycle 0, scramble inputs afterwards,
    // check busy/done each cycle 1..6 and the result in cycle 6 and 7.
    task automatic run_vec(input string name, input logic [31:0] dw, input logic [31:0] ww,
                           input logic [15:0] b, input logic [7:0] e1, input logic [7:0] e0);
        @(negedge clk);
        apply(dw, ww, b);
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            scramble();
            if (c <= 6) begin
                chk({name, " busy"}, {31'd0, busy}, {31'd0, (c <= 5)});
                chk({name, " done"}, {31'd0, done}, {31'd0, (c == 6)});
            end
            if (c >= 6) begin
                chk({name, " result relu"},   {24'd0, result},  {24'd0, e1});
                chk({name, " result norelu"}, {24'd0, result0}, {24'd0, e0});
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rw;
        logic [15:0] rb;

        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{32'h10101010, 32'h08080808, 16'h0080, 8'h05, 8'h05};
        vecs[1] = '{32'h80808080, 32'h80808080, 16'h7FFF, 8'h7F, 8'h7F};
        vecs[2] = '{32'h80808080, 32'h7F7F7F7F, 16'h0000, 8'h00, 8'h80};
        vecs[3] = '{32'h00000000, 32'h12345678, 16'hFFFF, 8'h00, 8'hFF};
        vecs[4] = '{32'h00000000, 32'h11111111, 16'h007F, 8'h00, 8'h00};
        vecs[5] = '{32'h04030201, 32'h08070605, 16'h03E8, 8'h08, 8'h08};
        vecs[6] = '{32'h00000000, 32'h00000000, 16'hFF7F, 8'h00, 8'hFE};

        rst   = 1'b1;
        start = 1'b0;
        apply(32'd0, 32'd0, 16'd0);
        repeat (3) @(negedge clk);
        chk("reset busy",   {31'd0, busy},   32'd0);
        chk("reset done",   {31'd0, done},   32'd0);
        chk("reset result", {24'd0, result}, 32'd0);
        rst = 1'b0;

        // Directed table; the first start follows reset release immediately.
        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].dw, vecs[i].ww, vecs[i].b,
                    vecs[i].e1, vecs[i].e0);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rd = $urandom;
            rw = $urandom;
            rb = 16'($urandom);
            if (i % 4 == 0) rb = 16'($urandom_range(0, 255)) - 16'd128;
            run_vec($sformatf("rand%0d", i), rd, rw, rb,
                    ref_out(rd, rw, rb, 1'b1), ref_out(rd, rw, rb, 1'b0));
        end

        // Start held high: second acceptance in cycle 6, second done in cycle 12.
        @(negedge clk);
        apply(vecs[0].dw, vecs[0].ww, vecs[0].b);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("b2b done c%0d", c), {31'd0, done}, {31'd0, (c == 6 || c == 12)});
            chk($sformatf("b2b busy c%0d", c), {31'd0, busy},
                {31'd0, ((c >= 1 && c <= 5) || (c >= 7 && c <= 11))});
            if (c == 6 || c == 12) chk("b2b result", {24'd0, result}, 32'd5);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Start pulse during MAC (cycle 3) is ignored: no second operation.
        @(negedge clk);
        apply(vecs[0].dw, vecs[0].ww, vecs[0].b);
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = (c == 3);
            if (c == 3) apply(vecs[1].dw, vecs[1].ww, vecs[1].b);
            chk($sformatf("midstart done c%0d", c), {31'd0, done}, {31'd0, (c == 6)});
            chk($sformatf("midstart busy c%0d", c), {31'd0, busy}, {31'd0, (c <= 5)});
        end
        chk("midstart result", {24'd0, result}, 32'd5);

        // Reset in cycle 3 aborts the operation and clears the held result.
        @(negedge clk);
        apply(vecs[1].dw, vecs[1].ww, vecs[1].b);
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("rst busy",    {31'd0, busy},    32'd0);
        chk("rst result",  {24'd0, result},  32'd0);
        chk("rst result0", {24'd0, result0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst done c%0d", c), {31'd0, done}, 32'd0);
            chk($sformatf("post-rst result c%0d", c), {24'd0, result}, 32'd0);
        end
        run_vec("after rst", vecs[0].dw, vecs[0].ww, vecs[0].b, 8'h05, 8'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_window.md
MAC_WINDOW -- requirements
Module: mac_window

Interface
REQ-001 SHALL have parameter SHIFT, default 7: arithmetic right-shift applied to the accumulated sum before saturation.
REQ-002 SHALL have parameter RELU, default 1: 1 = clamp negative results to 0 after saturation, 0 = pass signed result.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have ports:
  clk      input   1    rising-edge clock
  rst      input   1    asynchronous active-high reset
  start    input   1    request one dot-product; sampled only in IDLE
  din0..3  input   8    signed window bytes; byte order matches the upstream 4-byte window (din0 = oldest)
  wt0..3   input   8    signed weights, lane-matched to din0..3
  bias     input   16   signed bias
  busy     output  1    high while a computation is in progress
  done     output  1    one-cycle pulse, result valid
  result   output  8    registered output byte, held until next done or reset

Function
REQ-005 SHALL have states IDLE, MAC, OUT, DONE.
REQ-006 IDLE with start=1 at cycle 0 SHALL, in the same cycle:
  - latch din0..3, wt0..3
  - load the 20-bit signed accumulator with sign-extended bias
  - clear the 2-bit lane index
  - go to MAC
REQ-007 MAC (cycles 1-4) SHALL add one 16-bit signed product din[idx]*wt[idx] per cycle, sign-extended to 20 bits, lane 0 first, and increment idx; after lane 3 it SHALL go to OUT.
REQ-008 OUT (cycle 5) SHALL register into result: acc >>> SHIFT (arithmetic, floor rounding), saturated to [-128,127], then ReLU if RELU=1; it SHALL set done and go to DONE.
REQ-009 DONE (cycle 6) SHALL hold done=1 for exactly this cycle and return to IDLE.
REQ-010 busy SHALL be 1 in MAC and OUT (cycles 1-5), else 0.
REQ-011 DONE SHALL also accept start=1 exactly as IDLE does (back-to-back, cycle 6 = new cycle 0); result SHALL stay stable until the next OUT.
REQ-012 start during MAC or OUT SHALL be ignored, with no queuing.
REQ-013 din/wt/bias changes after the acceptance cycle SHALL NOT affect the computation in progress.
REQ-014 The accumulator SHALL NOT overflow for any input combination; worst case is 4*16384+32767 = 98303 < 2^19.
REQ-015 Saturation SHALL be applied to the full 20-bit shifted value, not a truncated one.

Reset
REQ-016 rst=1 SHALL immediately force:
  - state IDLE
  - busy=0, done=0, result=8'h00
  - accumulator, idx and latched operands to 0
REQ-017 rst asserted mid-operation SHALL abort it; no done pulse SHALL follow, and result stays 0.
REQ-018 After rst deasserts, the first start SHALL be accepted on the next rising edge in IDLE.

Verification
REQ-019 Basic: din=16 x4, wt=8 x4, bias=128 -> acc 640, result=8'd5; done high only in cycle 6; busy high cycles 1-5.
REQ-020 Positive saturation: din=-128 x4, wt=-128 x4, bias=32767 -> acc 98303, >>>7 = 767 -> result=8'd127; no accumulator wrap.
REQ-021 Negative with RELU: din=-128 x4, wt=127 x4, bias=0 -> acc -65024 -> -508 -> saturate -128.
  - RELU=1: result=8'h00
  - RELU=0: result=8'h80
REQ-022 Floor rounding, RELU=0: all din=0, bias=-1 -> result=8'hFF; with bias=127 -> result=8'h00.
REQ-023 Handshake:
  - start held high throughout the REQ-019 case -> second computation accepted in cycle 6, second done in cycle 12
  - start pulse in cycle 3 alone -> ignored
REQ-024 Reset: assert rst in cycle 3 of the REQ-019 case -> busy=0 and result=0 immediately; no done within 10 following cycles; a fresh start then yields result=8'd5.
